// File: rtl/dtm_jtag_dmi.sv
// dtm_jtag_dmi: JTAG Debug Transport Module with a configurable-width IR.
// Implements the IDCODE, BYPASS, DTMCS and DMI data registers. A DMI scan
// becomes a valid/ready request toward the debug module. The matching
// response is accepted with its own valid/ready pair, and the result is
// reported through a sticky busy/error status (dmistat).
//
// Ports (all logic runs in the tclk domain):
//   tclk            JTAG clock, the only clock
//   trst            asynchronous active-high reset
//   tms, tdi        TAP inputs, sampled on the rising edge
//   tdo             serial out, registered on the falling edge
//   tdo_en          high while in SHIFT_DR or SHIFT_IR
//   dmi_req_*       request toward the debug module (addr/data/op, valid/ready)
//   dmi_rsp_*       response from the debug module (data/op, valid/ready)
//
// TAP states:
//   state            | meaning
//   TEST_LOGIC_RESET | IR forced to IDCODE, DMI side hard-reset
//   RUN_TEST_IDLE    | idle
//   SELECT_DR_SCAN   | choose DR path or go on to the IR path
//   CAPTURE_DR       | load the selected DR on the rising edge
//   SHIFT_DR         | shift the selected DR, tdi enters its MSB
//   EXIT1/2_DR       | leave shift / pause
//   PAUSE_DR         | hold the DR
//   UPDATE_DR        | act on the DR contents on the edge that leaves it
//   SELECT_IR_SCAN   | choose IR path or go to TEST_LOGIC_RESET
//   CAPTURE_IR       | load 0...01 into the IR shifter
//   SHIFT_IR         | shift the IR shifter
//   EXIT1/2_IR       | leave shift / pause
//   PAUSE_IR         | hold the IR shifter
//   UPDATE_IR        | IR loaded from the shifter on the falling edge
module dtm_jtag_dmi #(
  parameter int unsigned IR_W         = 5,
  parameter int unsigned ABITS        = 7,
  parameter logic [31:0] IDCODE_VALUE = 32'h1BEEF001,
  parameter int unsigned IDLE_HINT    = 1
) (
  input  logic             tclk,
  input  logic             trst,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic             tdo_en,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_rsp_valid,
  output logic             dmi_rsp_ready,
  input  logic [31:0]      dmi_rsp_data,
  input  logic [1:0]       dmi_rsp_op
);

  localparam int unsigned DR_W = ABITS + 34;

  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(32'h01);
  localparam logic [IR_W-1:0] IR_DTMCS  = IR_W'(32'h10);
  localparam logic [IR_W-1:0] IR_DMI    = IR_W'(32'h11);

  localparam logic [5:0] ABITS_F = 6'(ABITS);
  localparam logic [2:0] IDLE_F  = 3'(IDLE_HINT);

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR_SCAN   = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR_SCAN   = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_DTMCS,
    SEL_DMI
  } dr_sel_e;

  tap_state_e       state_q, state_d;
  logic [IR_W-1:0]  ir_shift;
  logic [IR_W-1:0]  ir;
  dr_sel_e          dr_sel;
  logic [DR_W-1:0]  dr_shift, dr_next, dr_capture;
  logic [1:0]       dmistat;
  logic [ABITS-1:0] last_addr;
  logic [31:0]      last_rdata;

  // TAP state machine
  always_ff @(posedge tclk or posedge trst) begin
    if (trst) state_q <= TEST_LOGIC_RESET;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = TEST_LOGIC_RESET;
    unique case (state_q)
      TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  assign tdo_en = (state_q == SHIFT_DR) || (state_q == SHIFT_IR);

  // IR shifter on the rising edge, IR itself on the falling edge
  always_ff @(posedge tclk or posedge trst) begin
    if (trst) begin
      ir_shift <= IR_IDCODE;
    end else if (state_q == CAPTURE_IR) begin
      ir_shift <= IR_W'(32'h01);
    end else if (state_q == SHIFT_IR) begin
      ir_shift <= {tdi, ir_shift[IR_W-1:1]};
    end
  end

  always_ff @(negedge tclk or posedge trst) begin
    if (trst)                           ir <= IR_IDCODE;
    else if (state_q == TEST_LOGIC_RESET) ir <= IR_IDCODE;
    else if (state_q == UPDATE_IR)      ir <= ir_shift;
  end

  // Unknown codes fall through to BYPASS
  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir == IR_IDCODE)     dr_sel = SEL_IDCODE;
    else if (ir == IR_DTMCS) dr_sel = SEL_DTMCS;
    else if (ir == IR_DMI)   dr_sel = SEL_DMI;
  end

  // Handshake events and the "effective" view of status on this edge. A
  // response accepted on the same edge as a capture is folded in first so
  // the capture sees the post-response state. A hard reset on the same edge
  // swallows the response entirely.
  logic             req_fire, rsp_fire, rsp_take, hard_reset;
  logic             busy_eff;
  logic [1:0]       stat_eff, capture_op;
  logic [31:0]      rdata_eff;
  logic             upd_dmi, upd_dtmcs, cap_dmi;
  logic [1:0]       upd_op;
  logic [31:0]      upd_data;
  logic [ABITS-1:0] upd_addr;

  assign upd_dmi   = (state_q == UPDATE_DR)  && (dr_sel == SEL_DMI);
  assign upd_dtmcs = (state_q == UPDATE_DR)  && (dr_sel == SEL_DTMCS);
  assign cap_dmi   = (state_q == CAPTURE_DR) && (dr_sel == SEL_DMI);
  assign upd_op    = dr_shift[1:0];
  assign upd_data  = dr_shift[33:2];
  assign upd_addr  = dr_shift[DR_W-1:34];

  assign req_fire   = dmi_req_valid & dmi_req_ready;
  assign rsp_fire   = dmi_rsp_valid & dmi_rsp_ready;
  assign hard_reset = (upd_dtmcs && dr_shift[17]) || (state_q == TEST_LOGIC_RESET);
  assign rsp_take   = rsp_fire & ~hard_reset;

  assign busy_eff   = (dmi_req_valid | dmi_rsp_ready) & ~rsp_take;
  assign stat_eff   = (rsp_take && (dmi_rsp_op != 2'd0)) ? 2'd2 : dmistat;
  assign rdata_eff  = (rsp_take && (dmi_req_op == 2'd1)) ? dmi_rsp_data : last_rdata;
  assign capture_op = (stat_eff != 2'd0) ? stat_eff : (busy_eff ? 2'd3 : 2'd0);

  // DR capture and shift
  always_comb begin
    dr_capture = '0;
    unique case (dr_sel)
      SEL_IDCODE: dr_capture = DR_W'(IDCODE_VALUE);
      SEL_DTMCS:  dr_capture = DR_W'({14'b0, 2'b0, 1'b0, IDLE_F, stat_eff, ABITS_F, 4'd1});
      SEL_DMI:    dr_capture = {last_addr, rdata_eff, capture_op};
      default:    dr_capture = '0;
    endcase
  end

  always_comb begin
    dr_next = dr_shift >> 1;
    unique case (dr_sel)
      SEL_BYPASS: dr_next = {{(DR_W-1){1'b0}}, tdi};
      SEL_IDCODE: dr_next[31] = tdi;
      SEL_DTMCS:  dr_next[31] = tdi;
      SEL_DMI:    dr_next[DR_W-1] = tdi;
      default:    dr_next = dr_shift >> 1;
    endcase
  end

  always_ff @(posedge tclk or posedge trst) begin
    if (trst) begin
      dr_shift <= '0;
    end else if (state_q == CAPTURE_DR) begin
      dr_shift <= dr_capture;
    end else if (state_q == SHIFT_DR) begin
      dr_shift <= dr_next;
    end
  end

  always_ff @(negedge tclk or posedge trst) begin
    if (trst)                     tdo <= 1'b0;
    else if (state_q == SHIFT_DR) tdo <= dr_shift[0];
    else if (state_q == SHIFT_IR) tdo <= ir_shift[0];
  end

  // DMI request/response and sticky status. Later statements take priority:
  // hard reset overrides everything, and an error code is never downgraded
  // to busy.
  always_ff @(posedge tclk or posedge trst) begin
    if (trst) begin
      dmi_req_valid <= 1'b0;
      dmi_rsp_ready <= 1'b0;
      dmi_req_addr  <= '0;
      dmi_req_data  <= '0;
      dmi_req_op    <= '0;
      dmistat       <= '0;
      last_addr     <= '0;
      last_rdata    <= '0;
    end else begin
      if (req_fire) begin
        dmi_req_valid <= 1'b0;
        dmi_rsp_ready <= 1'b1;
      end
      if (rsp_take) begin
        dmi_rsp_ready <= 1'b0;
        last_rdata    <= rdata_eff;
        if (dmi_rsp_op != 2'd0) dmistat <= 2'd2;
      end
      if (cap_dmi && busy_eff && (stat_eff == 2'd0)) dmistat <= 2'd3;
      if (upd_dmi && ((upd_op == 2'd1) || (upd_op == 2'd2))) begin
        if (busy_eff) begin
          if (stat_eff == 2'd0) dmistat <= 2'd3;
        end else if (stat_eff == 2'd0) begin
          last_addr     <= upd_addr;
          dmi_req_addr  <= upd_addr;
          dmi_req_data  <= upd_data;
          dmi_req_op    <= upd_op;
          dmi_req_valid <= 1'b1;
        end
      end
      if (upd_dtmcs && (dr_shift[16] || dr_shift[17])) dmistat <= 2'd0;
      if (hard_reset) begin
        dmi_req_valid <= 1'b0;
        dmi_rsp_ready <= 1'b0;
        dmistat       <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_dtm_jtag_dmi.sv
module tb_dtm_jtag_dmi;

  logic        tclk = 1'b0;
  logic        trst = 1'b1;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        tdo;
  logic        tdo_en;
  logic        dmi_req_valid;
  logic        dmi_req_ready = 1'b0;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0]  dmi_req_op;
  logic        dmi_rsp_valid = 1'b0;
  logic        dmi_rsp_ready;
  logic [31:0] dmi_rsp_data = '0;
  logic [1:0]  dmi_rsp_op = '0;

  int total = 0;
  int bad = 0;

  dtm_jtag_dmi dut (
    .tclk(tclk), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
    .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_ready(dmi_rsp_ready),
    .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_op(dmi_rsp_op)
  );

  always #5 tclk = ~tclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                           input logic [1:0] o);
    return {23'b0, a, d, o};
  endfunction

  // One tclk cycle; entered and left at falling edge + 1
  task automatic step(input logic tms_v, input logic tdi_v, output logic tdo_v);
    tms = tms_v;
    tdi = tdi_v;
    tdo_v = tdo;
    @(posedge tclk);
    @(negedge tclk);
    #1;
  endtask

  task automatic idle();
    logic t;
    step(1'b0, 1'b0, t);
  endtask

  task automatic scan_ir(input logic [4:0] din, output logic [4:0] dout);
    logic t;
    dout = '0;
    step(1'b1, 1'b0, t);
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    step(1'b0, 1'b0, t);
    for (int i = 0; i < 5; i++) begin
      step(i == 4, din[i], t);
      dout[i] = t;
    end
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
  endtask

  task automatic scan_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
    logic t;
    dout = '0;
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    step(1'b0, 1'b0, t);
    chk("tdo_en_in_shift", {63'b0, tdo_en}, 64'd1);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], t);
      dout[i] = t;
    end
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
  endtask

  logic [4:0]  ir_out;
  logic [63:0] dr_out;
  logic        tt;

  initial begin
    // Reset values while trst is held
    #1;
    chk("rst_tdo", {63'b0, tdo}, 64'd0);
    chk("rst_tdo_en", {63'b0, tdo_en}, 64'd0);
    chk("rst_req_valid", {63'b0, dmi_req_valid}, 64'd0);
    chk("rst_rsp_ready", {63'b0, dmi_rsp_ready}, 64'd0);
    chk("rst_req_addr", {57'b0, dmi_req_addr}, 64'd0);
    chk("rst_req_data", {32'b0, dmi_req_data}, 64'd0);
    chk("rst_req_op", {62'b0, dmi_req_op}, 64'd0);
    @(negedge tclk);
    #1;
    trst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, tt);
    step(1'b0, 1'b0, tt);
    chk("tdo_en_idle", {63'b0, tdo_en}, 64'd0);

    // IDCODE selected after reset
    scan_dr(64'd0, 32, dr_out);
    chk("idcode", dr_out, 64'h1BEEF001);

    // IR capture and BYPASS: 1011 comes back one bit late
    scan_ir(5'b11111, ir_out);
    chk("ir_capture", {59'b0, ir_out}, 64'd1);
    scan_dr(64'b01011, 5, dr_out);
    chk("bypass", dr_out, 64'b10110);

    // DTMCS
    scan_ir(5'h10, ir_out);
    scan_dr(64'd0, 32, dr_out);
    chk("dtmcs", dr_out, 64'h00001071);

    // DMI write addr 0x10 data 1
    scan_ir(5'h11, ir_out);
    scan_dr(dmi_word(7'h10, 32'h1, 2'd2), 41, dr_out);
    chk("dmi_first_capture", dr_out, 64'd0);
    chk("wr_req_valid", {63'b0, dmi_req_valid}, 64'd1);
    chk("wr_req_addr", {57'b0, dmi_req_addr}, 64'h10);
    chk("wr_req_data", {32'b0, dmi_req_data}, 64'h1);
    chk("wr_req_op", {62'b0, dmi_req_op}, 64'd2);
    idle();
    idle();
    chk("wr_held", {63'b0, dmi_req_valid}, 64'd1);
    dmi_req_ready = 1'b1;
    idle();
    dmi_req_ready = 1'b0;
    chk("wr_accept_valid", {63'b0, dmi_req_valid}, 64'd0);
    chk("wr_accept_rsp_ready", {63'b0, dmi_rsp_ready}, 64'd1);
    dmi_rsp_valid = 1'b1;
    dmi_rsp_data = 32'hDEADBEEF;
    dmi_rsp_op = 2'd0;
    idle();
    dmi_rsp_valid = 1'b0;
    chk("wr_rsp_done", {63'b0, dmi_rsp_ready}, 64'd0);

    // DMI read of 0x10; write response must not have touched rdata
    scan_dr(dmi_word(7'h10, 32'h0, 2'd1), 41, dr_out);
    chk("after_write_capture", dr_out, dmi_word(7'h10, 32'h0, 2'd0));
    chk("rd_req_op", {62'b0, dmi_req_op}, 64'd1);
    dmi_req_ready = 1'b1;
    idle();
    dmi_req_ready = 1'b0;
    dmi_rsp_valid = 1'b1;
    dmi_rsp_data = 32'hCAFEF00D;
    dmi_rsp_op = 2'd0;
    idle();
    dmi_rsp_valid = 1'b0;
    scan_dr(64'd0, 41, dr_out);
    chk("read_back", dr_out, dmi_word(7'h10, 32'hCAFEF00D, 2'd0));

    // Sticky busy
    scan_dr(dmi_word(7'h05, 32'h12345678, 2'd2), 41, dr_out);
    dmi_req_ready = 1'b1;
    idle();
    dmi_req_ready = 1'b0;
    scan_dr(dmi_word(7'h06, 32'h0, 2'd2), 41, dr_out);
    chk("busy_capture", dr_out, dmi_word(7'h05, 32'hCAFEF00D, 2'd3));
    chk("busy_no_req", {63'b0, dmi_req_valid}, 64'd0);
    chk("busy_addr_kept", {57'b0, dmi_req_addr}, 64'h05);
    dmi_rsp_valid = 1'b1;
    dmi_rsp_op = 2'd0;
    dmi_rsp_data = 32'h0;
    idle();
    dmi_rsp_valid = 1'b0;
    scan_dr(dmi_word(7'h07, 32'h0, 2'd1), 41, dr_out);
    chk("sticky_op", {62'b0, dr_out[1:0]}, 64'd3);
    chk("sticky_no_req", {63'b0, dmi_req_valid}, 64'd0);
    chk("sticky_addr_kept", {57'b0, dmi_req_addr}, 64'h05);
    scan_ir(5'h10, ir_out);
    scan_dr(64'h10000, 32, dr_out);
    chk("dtmcs_busy", dr_out, 64'h00001C71);
    scan_ir(5'h11, ir_out);
    scan_dr(64'd0, 41, dr_out);
    chk("dmireset_clears", dr_out, dmi_word(7'h05, 32'hCAFEF00D, 2'd0));

    // Failed response
    scan_dr(dmi_word(7'h09, 32'h0, 2'd1), 41, dr_out);
    dmi_req_ready = 1'b1;
    idle();
    dmi_req_ready = 1'b0;
    dmi_rsp_valid = 1'b1;
    dmi_rsp_data = 32'hCAFEF00D;
    dmi_rsp_op = 2'd2;
    idle();
    dmi_rsp_valid = 1'b0;
    scan_dr(64'd0, 41, dr_out);
    chk("failed_op", {62'b0, dr_out[1:0]}, 64'd2);
    scan_ir(5'h10, ir_out);
    scan_dr(64'h10000, 32, dr_out);
    chk("dtmcs_failed", dr_out, 64'h00001871);

    // dmihardreset while a request is pending
    scan_ir(5'h11, ir_out);
    scan_dr(dmi_word(7'h0A, 32'h77, 2'd2), 41, dr_out);
    scan_ir(5'h10, ir_out);
    chk("hr_pending", {63'b0, dmi_req_valid}, 64'd1);
    scan_dr(64'h20000, 32, dr_out);
    chk("hr_dtmcs_capture", dr_out, 64'h00001071);
    chk("hr_valid_dropped", {63'b0, dmi_req_valid}, 64'd0);
    dmi_rsp_valid = 1'b1;
    dmi_rsp_data = 32'h55555555;
    dmi_rsp_op = 2'd2;
    idle();
    dmi_rsp_valid = 1'b0;
    chk("hr_rsp_ready", {63'b0, dmi_rsp_ready}, 64'd0);
    scan_ir(5'h11, ir_out);
    scan_dr(64'd0, 41, dr_out);
    chk("hr_late_rsp_ignored", dr_out, dmi_word(7'h0A, 32'hCAFEF00D, 2'd0));

    // trst in the middle of a request
    scan_dr(dmi_word(7'h33, 32'hA5A5A5A5, 2'd2), 41, dr_out);
    chk("trst_pre_valid", {63'b0, dmi_req_valid}, 64'd1);
    #2;
    trst = 1'b1;
    #1;
    chk("trst_valid", {63'b0, dmi_req_valid}, 64'd0);
    chk("trst_rsp_ready", {63'b0, dmi_rsp_ready}, 64'd0);
    chk("trst_addr", {57'b0, dmi_req_addr}, 64'd0);
    chk("trst_data", {32'b0, dmi_req_data}, 64'd0);
    chk("trst_op", {62'b0, dmi_req_op}, 64'd0);
    chk("trst_tdo", {63'b0, tdo}, 64'd0);
    chk("trst_tdo_en", {63'b0, tdo_en}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dtm_jtag_dmi.md
# dtm_jtag_dmi

Parametrised JTAG Debug Transport Module and successor to the fixed-function TAP. It has a configurable-width IR and implements IDCODE, BYPASS, DTMCS and DMI registers. DMI scans are turned into a valid/ready request/response transaction toward the debug module, with sticky busy/error status. It sits between the board JTAG pins and the debug module, and all logic runs in the `tclk` domain.

## Interface
- `IR_W`, default 5: instruction register width; must be ≥5.
- `ABITS`, default 7: DMI address width, 1..32.
- `IDCODE_VALUE`, default 32'h1BEEF001: value captured by IDCODE.
- `IDLE_HINT`, default 1: 3-bit value reported in DTMCS.idle.

Ports:
- `tclk`  in  1  JTAG clock. The only clock.
- `trst`  in  1  reset; asynchronous, active-high.
- `tms`  in  1  TAP mode select, sampled on the rising edge of `tclk`.
- `tdi`  in  1  serial in, sampled on the rising edge.
- `tdo`  out  1  serial out, registered on the falling edge.
- `tdo_en`  out  1  high in SHIFT_DR and SHIFT_IR.
- `dmi_req_valid`  out  1  request valid.
- `dmi_req_ready`  in  1  request accepted.
- `dmi_req_addr`  out  ABITS  request address.
- `dmi_req_data`  out  32  write data.
- `dmi_req_op`  out  2  1=read, 2=write.
- `dmi_rsp_valid`  in  1  response valid.
- `dmi_rsp_ready`  out  1  high while awaiting a response.
- `dmi_rsp_data`  in  32  read data.
- `dmi_rsp_op`  in  2  0=ok, 2=failed. Any other value is treated as failed.

## Operation
- **TAP FSM:** standard IEEE 1149.1 16-state machine, advanced on the rising edge.
  - Entry: reset enters TEST_LOGIC_RESET.
  - Default: illegal state goes to TEST_LOGIC_RESET.
- **IR:**
  - CAPTURE_IR loads `{(IR_W-1)'b0,1'b1}`.
  - SHIFT_IR shifts right with `tdi` entering the MSB.
  - UPDATE_IR loads the IR on the falling edge.
  - TEST_LOGIC_RESET forces IR to IDCODE.
- **Instruction decode:** IDCODE=1, DTMCS=0x10, DMI=0x11, BYPASS=all ones. Any other code selects BYPASS.
- **DR select:** the instruction selects the DR. All DRs are captured in CAPTURE_DR, shift LSB-first, and `tdi` enters the MSB.
  - IDCODE: 32 bits, captures `IDCODE_VALUE`.
  - BYPASS: 1 bit, captures 0.
  - DTMCS: 32 bits, captures `{14'b0, 2'b0, 1'b0, IDLE_HINT[2:0], dmistat[1:0], ABITS[5:0], 4'd1}`.
  - DMI: `ABITS+34` bits = `{addr, data, op}`. Captures `{last_addr, last_rdata, capture_op}`.
- **capture_op:** equals `dmistat` if nonzero; else 3 if busy; else 0.
- **Side effect of capture while busy:** if busy at capture, `dmistat` is set to 3 (sticky).
- **busy definition:** `dmi_req_valid` or `dmi_rsp_ready` is high.
- **UPDATE_DR with DTMCS:**
  - bit16 (dmireset) clears `dmistat`.
  - bit17 (dmihardreset) clears `dmistat`, drops `dmi_req_valid` and `dmi_rsp_ready`, and discards any later response.
- **UPDATE_DR with DMI, op ∈ {1,2}:**
  - If busy: set `dmistat`=3 and issue no request.
  - Else if `dmistat`≠0: ignore the update.
  - Else: latch addr/data/op into `last_addr` and the request registers, and assert `dmi_req_valid`.
  - op 0 or 3: no action.
- **Request/response handshake:**
  - The request is held stable until `dmi_req_valid & dmi_req_ready` on a rising edge.
  - On that edge `dmi_req_valid` goes to 0 and `dmi_rsp_ready` goes to 1.
  - On `dmi_rsp_valid & dmi_rsp_ready`: `dmi_rsp_ready` goes to 0.
  - For a read, `last_rdata` ← `dmi_rsp_data`. Writes leave `last_rdata` unchanged.
  - If `dmi_rsp_op`≠0, `dmistat` ← 2 (failed). This error is sticky and overwrites busy.
- **TEST_LOGIC_RESET:** behaves as dmihardreset and sets IR to IDCODE.

## Timing
- **Reset values:** `tdo`=0, `tdo_en`=0, `dmi_req_valid`=0, `dmi_rsp_ready`=0, `dmi_req_addr/data/op`=0, `dmistat`=0, `last_addr`=0, `last_rdata`=0, IR=IDCODE.
- **Reset is asynchronous:** `dmi_req_valid` drops immediately when `trst` asserts, mid-handshake included.
- **TDO timing:** `tdo` updates on the falling edge to the current LSB of the selected shift register, so data is valid on the next rising edge. Outside SHIFT states `tdo` holds its value.
- **Request latency:** `dmi_req_valid` rises on the rising edge that leaves UPDATE_DR, i.e. 1 `tclk` after UPDATE_DR is entered.
- **Minimum round trip:** 1 cycle for request accept plus 1 cycle for response.
- **Simultaneous events:**
  - Response accept on the same edge as CAPTURE_DR: capture sees not-busy and captures the new `rdata`. The response path has priority.
  - dmihardreset on the same edge as a response: the response is discarded.
- **Address width:** `dmi_req_addr` is exactly ABITS wide; no truncation occurs.

## Test plan
- **IDCODE after reset:** `trst` pulse, then go to SHIFT_DR and shift 32 bits -> `tdo` emits 0x1BEEF001 LSB-first.
- **IR capture and BYPASS:** IR scan shifts out 5'b00001. Load 5'b11111, then a DR scan of pattern 1011 -> `tdo` returns the same pattern delayed 1 bit.
- **DTMCS read:** with ABITS=7, IDLE_HINT=1, a DTMCS capture -> 0x00001071.
- **DMI write, then read back:**
  - Write addr 0x10, data 0x00000001, op 2 -> `dmi_req_*` = 0x10/0x1/2; ready after 3 cycles; response op 0.
  - Next DMI read of 0x10 returns data 0xCAFEF00D.
  - Following capture -> op 0, data 0xCAFEF00D.
- **Sticky busy:** UPDATE_DR on DMI while the response is pending -> no new request; capture shows op 3.
  - Every further DMI update is ignored.
  - DTMCS write with bit16 set -> capture op 0.
- **Failure and resets:**
  - Response op 2 -> capture op 2.
  - dmihardreset while `dmi_req_valid` is high -> valid drops the next cycle and a late `dmi_rsp_valid` is ignored.
  - `trst` mid-request -> all outputs at their reset values.
